// File: rtl/manette_gen.sv
// ---------------------------------------------------------------------------
// manette_gen -- paddle column controller driven by two push buttons.
//
// Each raw button goes through a 2-flop synchroniser and its own debounce
// counter. A debounced rising level makes a move attempt. Holding the button
// makes a further attempt every REPEAT cycles. An attempt targets the
// neighbouring column. The target is accepted only if that column's stack
// height does not exceed the current paddle row.
//
// Parameters
//   NCOL     number of columns (2..16)
//   HW       width of height / row values
//   DEB      debounce stability length in cycles (>=1)
//   REPEAT   auto-repeat period in cycles (>=2)
//   INIT_COL column loaded at reset (< NCOL)
//   WRAP     0 = saturate at the edges, 1 = wrap around
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   boutonPlus  raw asynchronous move-right button
//   boutonMoins raw asynchronous move-left button
//   hauteurs    stack heights, column i at [i*HW +: HW]
//   row         current paddle row
//   col         registered current column
//   moved       one-cycle pulse when col changed
//   blocked     one-cycle pulse when a move attempt was refused
// ---------------------------------------------------------------------------
module manette_gen #(
  parameter int  NCOL     = 3,
  parameter int  HW       = 3,
  parameter int  DEB      = 4,
  parameter int  REPEAT   = 16,
  parameter int  INIT_COL = 1,
  parameter int  WRAP     = 0,
  localparam int CW       = (NCOL > 2) ? $clog2(NCOL) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boutonPlus,
  input  logic               boutonMoins,
  input  logic [NCOL*HW-1:0] hauteurs,
  input  logic [HW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic               moved,
  output logic               blocked
);

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;  // debounce counter width
  localparam int RW = $clog2(REPEAT);               // repeat counter width

  // Index 0 = plus button, index 1 = minus button.
  logic [1:0]         raw_s;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0][DW-1:0] deb_q, deb_d;
  logic [1:0][RW-1:0] rep_q, rep_d;
  logic [1:0]         fire_s;

  logic               try_plus_s, try_minus_s;
  logic               tgt_valid_s, accept_s;
  logic [CW-1:0]      tgt_s;
  logic [HW-1:0]      tgt_h_s;

  logic [CW-1:0]      col_q, col_d;
  logic               moved_q, moved_d;
  logic               blocked_q, blocked_d;

  assign raw_s = {boutonMoins, boutonPlus};

  // Debounce and auto-repeat per button; fire_s marks an attempt request.
  always_comb begin
    lvl_d  = lvl_q;
    deb_d  = '0;
    rep_d  = '0;
    fire_s = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != lvl_q[b]) begin
        // The level flips on the DEB-th consecutive disagreeing sample.
        // The attempt is taken in that same cycle, so col updates at the
        // edge where the level flips.
        if (deb_q[b] == DW'(DEB - 1)) begin
          lvl_d[b] = sync2_q[b];
        end else begin
          deb_d[b] = deb_q[b] + DW'(1);
        end
      end else begin
        deb_d[b] = '0;
      end

      if (!lvl_d[b]) begin
        rep_d[b] = '0;
      end else if (!lvl_q[b]) begin
        fire_s[b] = 1'b1;
        rep_d[b]  = '0;
      end else if (rep_q[b] == RW'(REPEAT - 1)) begin
        fire_s[b] = 1'b1;
        rep_d[b]  = '0;
      end else begin
        rep_d[b] = rep_q[b] + RW'(1);
      end
    end
  end

  // Both buttons held: suppress attempts, but the counters keep running.
  assign try_plus_s  = fire_s[0] & ~(lvl_d[0] & lvl_d[1]);
  assign try_minus_s = fire_s[1] & ~(lvl_d[0] & lvl_d[1]);

  // Target column, edge handling, height lookup and next-state outputs.
  always_comb begin
    tgt_s       = col_q;
    tgt_valid_s = 1'b0;
    if (try_plus_s) begin
      if (col_q == CW'(NCOL - 1)) begin
        tgt_s       = '0;
        tgt_valid_s = (WRAP != 0);
      end else begin
        tgt_s       = col_q + CW'(1);
        tgt_valid_s = 1'b1;
      end
    end else if (try_minus_s) begin
      if (col_q == '0) begin
        tgt_s       = CW'(NCOL - 1);
        tgt_valid_s = (WRAP != 0);
      end else begin
        tgt_s       = col_q - CW'(1);
        tgt_valid_s = 1'b1;
      end
    end else begin
      tgt_s       = col_q;
      tgt_valid_s = 1'b0;
    end

    // The loop only covers real columns, so a non-power-of-two NCOL never
    // reads past the hauteurs vector.
    tgt_h_s = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (tgt_s == CW'(i)) begin
        tgt_h_s = hauteurs[i*HW +: HW];
      end else begin
        tgt_h_s = tgt_h_s;
      end
    end
    accept_s = tgt_valid_s && (tgt_h_s <= row);

    col_d     = col_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (try_plus_s || try_minus_s) begin
      if (accept_s) begin
        col_d   = tgt_s;
        moved_d = 1'b1;
      end else begin
        blocked_d = 1'b1;
      end
    end else begin
      col_d = col_q;
    end
  end

  // State registers: synchronisers, debounce/repeat counters, outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      lvl_q     <= 2'b00;
      deb_q     <= '0;
      rep_q     <= '0;
      col_q     <= CW'(INIT_COL);
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      sync1_q   <= raw_s;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      deb_q     <= deb_d;
      rep_q     <= rep_d;
      col_q     <= col_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign col     = col_q;
  assign moved   = moved_q;
  assign blocked = blocked_q;

endmodule
